// File: rtl/bp_if.sv
// -----------------------------------------------------------------------------
// bp_if
// Bundle between the fetch/execute side and the branch direction predictor.
//
//   predict_valid    fetch -> bp   branch presented for prediction this cycle
//   predict_pc       fetch -> bp   PC of that branch
//   predict_ready    bp -> fetch   queue not full, prediction can be accepted
//   predict_taken    bp -> fetch   combinational direction guess
//   resolve_valid    exec -> bp    oldest in-flight branch resolves this cycle
//   resolve_taken    exec -> bp    actual direction of that branch
//   mispredict       bp -> fetch   registered one-cycle redirect pulse
//   mispredict_count bp -> core    saturating count of mispredicts
//
// master: the core side (fetch + execute); slave: the predictor.
// -----------------------------------------------------------------------------
interface bp_if;
    logic        predict_valid;
    logic [31:0] predict_pc;
    logic        predict_ready;
    logic        predict_taken;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        mispredict;
    logic [15:0] mispredict_count;

    modport master (
        output predict_valid,
        output predict_pc,
        output resolve_valid,
        output resolve_taken,
        input  predict_ready,
        input  predict_taken,
        input  mispredict,
        input  mispredict_count
    );

    modport slave (
        input  predict_valid,
        input  predict_pc,
        input  resolve_valid,
        input  resolve_taken,
        output predict_ready,
        output predict_taken,
        output mispredict,
        output mispredict_count
    );
endinterface

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// PC-indexed table of 2-bit saturating counters with an in-order queue of
// outstanding guesses. Each resolution pops the oldest guess, trains its
// counter, and on disagreement raises a one-cycle mispredict pulse and flushes
// the younger (wrong-path) guesses.
//
// Ports:
//   i_clk  core clock, rising edge
//   i_rst  asynchronous active-high reset
//   bp     bp_if.slave: predict request/response, resolve, mispredict outputs
//
// Parameters:
//   INDEX_BITS   log2 of the number of counters; index = predict_pc[INDEX_BITS+1:2]
//   QUEUE_DEPTH  maximum unresolved predictions in flight (power of two, >= 2)
// -----------------------------------------------------------------------------
module branch_predictor #(
    parameter int INDEX_BITS  = 6,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    bp_if.slave  bp
);

    localparam int TABLE_SIZE = 1 << INDEX_BITS;
    localparam int PTR_BITS   = $clog2(QUEUE_DEPTH);
    localparam int OCC_BITS   = PTR_BITS + 1;

    localparam logic [1:0] CTR_WEAK_NT = 2'b01;

    typedef struct packed {
        logic [INDEX_BITS-1:0] index;
        logic                  guess;
    } q_entry_t;

    // Counter table and guess queue
    logic [1:0]          r_table [TABLE_SIZE];
    q_entry_t            r_queue [QUEUE_DEPTH];
    logic [PTR_BITS-1:0] r_wr_ptr;
    logic [PTR_BITS-1:0] r_rd_ptr;
    logic [OCC_BITS-1:0] r_occ;
    logic                r_mispredict;
    logic [15:0]         r_mis_count;

    logic [INDEX_BITS-1:0] w_pred_index;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_resolve;
    logic                  w_wrong;
    logic                  w_push;
    q_entry_t              w_head;
    logic [1:0]            w_head_ctr;
    logic [1:0]            w_next_ctr;
    logic                  w_unused_pc;

    assign w_pred_index = bp.predict_pc[INDEX_BITS+1:2];
    assign w_unused_pc  = ^{bp.predict_pc[31:INDEX_BITS+2], bp.predict_pc[1:0]};

    // Ready looks only at registered occupancy: a full queue stays not-ready
    // even in a cycle that pops, so there is no pop-to-ready bypass path.
    assign w_ready   = (r_occ < OCC_BITS'(QUEUE_DEPTH));
    assign w_accept  = bp.predict_valid && w_ready;
    assign w_resolve = bp.resolve_valid && (r_occ != '0);
    assign w_head    = r_queue[r_rd_ptr];
    assign w_wrong   = w_resolve && (w_head.guess != bp.resolve_taken);
    // A push alongside a mispredicting resolve is wrong-path and is dropped.
    assign w_push    = w_accept && !w_wrong;

    assign w_head_ctr = r_table[w_head.index];

    // Saturating increment/decrement of the head's counter
    always_comb begin
        // NOTE: default assignment first so no path through this block leaves
        // w_next_ctr unassigned, which would infer a latch.
        w_next_ctr = w_head_ctr;
        if (bp.resolve_taken) begin
            if (w_head_ctr != 2'b11) w_next_ctr = w_head_ctr + 2'b01;
        end else begin
            if (w_head_ctr != 2'b00) w_next_ctr = w_head_ctr - 2'b01;
        end
    end

    // Counter table. A same-index read in the update cycle sees the old value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            // NOTE: this table must reset to weak-not-taken in every entry, so
            // it is built from resettable flops rather than an un-reset RAM.
            for (int i = 0; i < TABLE_SIZE; i++) begin
                r_table[i] <= CTR_WEAK_NT;
            end
        end else if (w_resolve) begin
            // NOTE: non-blocking assignments for all sequential state so every
            // reader in this edge sees the pre-edge values.
            r_table[w_head.index] <= w_next_ctr;
        end
    end

    // Queue payload needs no reset: entries are only read while occupancy
    // says they are valid.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_queue[r_wr_ptr] <= '{index: w_pred_index, guess: bp.predict_taken};
        end
    end

    // Queue pointers and occupancy
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else if (w_wrong) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push)    r_wr_ptr <= r_wr_ptr + PTR_BITS'(1);
            if (w_resolve) r_rd_ptr <= r_rd_ptr + PTR_BITS'(1);
            case ({w_push, w_resolve})
                2'b10:   r_occ <= r_occ + OCC_BITS'(1);
                2'b01:   r_occ <= r_occ - OCC_BITS'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Mispredict pulse and saturating counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mispredict <= 1'b0;
            r_mis_count  <= '0;
        end else begin
            r_mispredict <= w_wrong;
            if (w_wrong && (r_mis_count != 16'hFFFF)) begin
                r_mis_count <= r_mis_count + 16'd1;
            end
        end
    end

    assign bp.predict_ready    = w_ready;
    assign bp.predict_taken    = r_table[w_pred_index][1];
    assign bp.mispredict       = r_mispredict;
    assign bp.mispredict_count = r_mis_count;

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Directed bench for branch_predictor. Inputs change and outputs are sampled
// around the falling edge; the design updates on the rising edge.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;

    bit exp_sat_mis [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bit exp_sat_tk  [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    bp_if bus ();

    branch_predictor #(
        .INDEX_BITS  (6),
        .QUEUE_DEPTH (2)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bp    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One rising edge, return at the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic accept(input logic [31:0] pc);
        bus.predict_valid = 1'b1;
        bus.predict_pc    = pc;
        step();
        bus.predict_valid = 1'b0;
    endtask

    task automatic resolve(input logic taken);
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = taken;
        step();
        bus.resolve_valid = 1'b0;
    endtask

    task automatic peek(input string tag, input logic [31:0] pc, input logic exp);
        bus.predict_pc = pc;
        #1;
        check(tag, bus.predict_taken, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst               = 1'b1;
        bus.predict_valid = 1'b0;
        bus.predict_pc    = 32'h0;
        bus.resolve_valid = 1'b0;
        bus.resolve_taken = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state
        bus.predict_valid = 1'b1;
        bus.predict_pc    = 32'h40;
        #1;
        check("rst_taken", bus.predict_taken, 0);
        check("rst_ready", bus.predict_ready, 1);
        check("rst_mis", bus.mispredict, 0);
        check("rst_count", bus.mispredict_count, 0);

        // Train 0x40: 01 -> 10 (mispredict) -> 11
        accept(32'h40);
        resolve(1'b1);
        check("train1_mis", bus.mispredict, 1);
        check("train1_count", bus.mispredict_count, 1);
        peek("train1_taken", 32'h40, 1);
        step();
        check("train1_pulse_end", bus.mispredict, 0);
        accept(32'h40);
        resolve(1'b1);
        check("train2_mis", bus.mispredict, 0);
        check("train2_count", bus.mispredict_count, 1);
        peek("train3_taken", 32'h40, 1);

        // Saturation toward 00: counters 11->10->01->00->00->00
        for (int i = 0; i < 5; i++) begin
            accept(32'h40);
            resolve(1'b0);
            check($sformatf("sat%0d_mis", i), bus.mispredict, 32'(exp_sat_mis[i]));
            peek($sformatf("sat%0d_taken", i), 32'h40, exp_sat_tk[i]);
        end
        check("sat_count", bus.mispredict_count, 3);
        // From a saturated 00, one taken resolve lands on 01
        accept(32'h40);
        resolve(1'b1);
        check("sat_up_mis", bus.mispredict, 1);
        check("sat_up_count", bus.mispredict_count, 4);
        peek("sat_up_taken", 32'h40, 0);

        // Queue full, blocked accept, then flush
        accept(32'h80);
        check("q1_ready", bus.predict_ready, 1);
        accept(32'h84);
        check("q2_ready", bus.predict_ready, 0);
        bus.predict_valid = 1'b1;
        bus.predict_pc    = 32'h88;
        step();
        bus.predict_valid = 1'b0;
        check("qfull_ready", bus.predict_ready, 0);
        resolve(1'b1);
        check("flush_mis", bus.mispredict, 1);
        check("flush_count", bus.mispredict_count, 5);
        check("flush_ready", bus.predict_ready, 1);
        peek("flush_80_taken", 32'h80, 1);
        peek("flush_84_taken", 32'h84, 0);
        // Queue is empty now: this resolve must be ignored
        resolve(1'b1);
        check("flush_empty_mis", bus.mispredict, 0);
        check("flush_empty_count", bus.mispredict_count, 5);
        peek("flush_84_still", 32'h84, 0);
        peek("flush_88_still", 32'h88, 0);

        // Simultaneous push and correct resolve: occupancy stays 1
        accept(32'h40);                       // guess 0, entry 16 = 01
        bus.predict_valid = 1'b1;
        bus.predict_pc    = 32'hC0;           // guess 0, entry 48 = 01
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = 1'b0;
        step();
        bus.predict_valid = 1'b0;
        bus.resolve_valid = 1'b0;
        check("simok_mis", bus.mispredict, 0);
        check("simok_ready", bus.predict_ready, 1);
        accept(32'h80);                       // guess 1, entry 32 = 10
        check("simok_full", bus.predict_ready, 0);
        resolve(1'b0);                        // head is 0xC0, guessed 0
        check("simok_head_mis", bus.mispredict, 0);
        resolve(1'b1);                        // next is 0x80, guessed 1
        check("simok_tail_mis", bus.mispredict, 0);
        check("simok_count", bus.mispredict_count, 5);
        check("simok_empty_ready", bus.predict_ready, 1);
        peek("simok_40_taken", 32'h40, 0);
        peek("simok_c0_taken", 32'hC0, 0);
        peek("simok_80_taken", 32'h80, 1);

        // Simultaneous push and wrong resolve: push discarded, occupancy 0
        accept(32'h40);                       // guess 0, entry 16 = 00
        bus.predict_valid = 1'b1;
        bus.predict_pc    = 32'h80;           // guess 1
        bus.resolve_valid = 1'b1;
        bus.resolve_taken = 1'b1;
        step();
        bus.predict_valid = 1'b0;
        bus.resolve_valid = 1'b0;
        check("simbad_mis", bus.mispredict, 1);
        check("simbad_count", bus.mispredict_count, 6);
        check("simbad_ready", bus.predict_ready, 1);
        resolve(1'b0);                        // would mispredict if 0x80 was kept
        check("simbad_empty_mis", bus.mispredict, 0);
        check("simbad_empty_count", bus.mispredict_count, 6);
        peek("simbad_40_taken", 32'h40, 0);

        // Reset asserted while a mispredict pulse is high
        accept(32'h40);                       // guess 0, entry 16 = 01
        resolve(1'b1);                        // entry 16 -> 10
        check("pre_rst_mis", bus.mispredict, 1);
        check("pre_rst_count", bus.mispredict_count, 7);
        rst = 1'b1;
        #1;
        check("async_rst_mis", bus.mispredict, 0);
        check("async_rst_count", bus.mispredict_count, 0);
        check("async_rst_ready", bus.predict_ready, 1);
        peek("async_rst_40", 32'h40, 0);
        peek("async_rst_80", 32'h80, 0);
        @(negedge clk);
        rst = 1'b0;

        // Empty-queue resolve after reset is ignored
        resolve(1'b1);
        check("empty_mis", bus.mispredict, 0);
        check("empty_count", bus.mispredict_count, 0);
        peek("empty_40_taken", 32'h40, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch direction predictor for the fetch side of the core. It guesses, at fetch time, the outcome that the control transfer unit later resolves at execute. It is indexed by PC and uses a table of 2-bit saturating counters. Each accepted guess is held in an in-order queue until its resolution arrives. A registered mispredict pulse is raised when the resolution disagrees with the guess, and that pulse triggers the fetch redirect.

## Interface
- INDEX_BITS, 6: table has 2^INDEX_BITS counters; index = predict_pc[INDEX_BITS+1:2].
- QUEUE_DEPTH, 2: maximum number of unresolved predictions in flight; power of two, at least 2.
- clock  in  1  core clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- predict_valid  in  1  fetch presents a conditional branch to be predicted this cycle.
- predict_pc  in  32  PC of that branch.
- predict_ready  out  1  queue not full; a prediction is accepted when predict_valid && predict_ready.
- predict_taken  out  1  combinational guess = MSB of the counter at the indexed entry; valid whenever predict_valid.
- resolve_valid  in  1  execute resolves the oldest in-flight branch this cycle.
- resolve_taken  in  1  actual outcome (take_branch from control transfer).
- mispredict  out  1  registered one-cycle pulse: the resolved guess was wrong.
- mispredict_count  out  16  saturating count of mispredicts since reset.

## Operation
- Table: 2^INDEX_BITS 2-bit counters. 00 strong-not-taken, 01 weak-not-taken, 10 weak-taken, 11 strong-taken. All entries reset to 01.
- Accept: push {index, predict_taken} at the queue tail and increment occupancy.
- Resolve with a non-empty queue:
  - Pop the head.
  - Update the head's entry: resolve_taken increments the counter (saturating at 11); otherwise it decrements (saturating at 00).
  - If the stored guess != resolve_taken, set mispredict at the next edge, increment mispredict_count (saturating at 0xFFFF), and flush the remaining queue (occupancy becomes 0, pointers reset). Younger entries are wrong-path.
- Resolve with an empty queue: ignored. No table update, no mispredict.
- Simultaneous accept and resolve:
  - Correct resolve: pop and push both happen; occupancy is unchanged.
  - Mispredicting resolve: the same-cycle push is discarded, because it is wrong-path. Occupancy becomes 0.
- Same-index read and update in one cycle: predict_taken reflects the pre-update counter. The write is visible from the next cycle.
- predict_ready depends only on registered occupancy (occupancy < QUEUE_DEPTH). There is no same-cycle pop bypass.
- Counter and queue state is not affected by predict_valid when predict_ready = 0.

## Timing
- Reset values:
  - predict_ready = 1
  - mispredict = 0
  - mispredict_count = 0
  - queue empty
  - all counters = 01, so predict_taken = 0 for every PC.
- Reset asserted mid-operation clears all of the above immediately (asynchronously). Any pending mispredict pulse is lost.
- Prediction latency: 0 cycles, combinational from predict_pc.
- Resolution-to-mispredict latency: 1 cycle. mispredict is high for exactly one cycle per wrong resolution.
- Back-to-back wrong resolutions are impossible after a flush, because the queue is empty. Back-to-back correct resolutions are supported every cycle.
- Table update visible to predictions 1 cycle after the resolve edge.

## Test plan
- Reset, then predict_valid=1, predict_pc=0x0000_0040 → predict_taken=0, predict_ready=1, mispredict=0, mispredict_count=0.
- Train PC 0x40: two accept/resolve_taken=1 pairs, one at a time → first resolve raises mispredict for 1 cycle; entry 16 goes 01→10→11; third predict at 0x40 gives predict_taken=1; mispredict_count=1.
- Saturation: five resolve_taken=0 for PC 0x40 starting from 11 → counter goes 10, 01, 00, 00, 00; predict_taken=0 after the second resolve.
- Queue full and flush:
  - Accept PCs 0x80 and 0x84 (both predicted 0) → predict_ready=0 and the next predict_valid is not accepted.
  - Resolve the head with resolve_taken=1 → mispredict=1 next cycle; queue empty; predict_ready=1; entry for 0x84 unchanged.
- Simultaneous events:
  - With one correct-pending entry, accept a new PC in the resolve cycle → occupancy stays 1.
  - Repeat with a wrong resolution → occupancy 0 and the pushed guess is discarded.
- Empty-queue resolve: resolve_valid=1 after reset → no mispredict, table unchanged. Asserting reset mid-pulse clears mispredict and mispredict_count immediately.
